// File: rtl/gold_nic_buffered.sv
// Buffered gold NIC: CPU register port plus ring-router port, with DEPTH-deep
// injection (CPU->net) and ejection (net->CPU) FIFOs, polarity gating and a sticky overflow flag.
module gold_nic_buffered #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter int VC_BIT   = 63,
  parameter int POL_GATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  input  logic             nicEn,
  input  logic             nicWrEn,
  input  logic             net_polarity,
  output logic             net_so,
  input  logic             net_ro,
  output logic [WIDTH-1:0] net_do,
  input  logic             net_si,
  output logic             net_ri,
  input  logic [WIDTH-1:0] net_di
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] inj_mem [DEPTH];
  logic [WIDTH-1:0] ej_mem  [DEPTH];
  logic [AW-1:0]    inj_wr, inj_rd, ej_wr, ej_rd;
  logic [CW-1:0]    inj_count, ej_count;
  logic             ovf;

  logic             inj_empty, inj_full, ej_empty, ej_full;
  logic [WIDTH-1:0] inj_head, ej_head;
  logic             pol_ok;
  logic             cpu_wr, cpu_rd;
  logic             inj_push_req, inj_push, inj_pop, ovf_set, ovf_clr;
  logic             ej_push, ej_pop;

  assign inj_empty = (inj_count == '0);
  assign inj_full  = (inj_count == CW'(DEPTH));
  assign ej_empty  = (ej_count == '0);
  assign ej_full   = (ej_count == CW'(DEPTH));
  assign inj_head  = inj_mem[inj_rd];
  assign ej_head   = ej_mem[ej_rd];

  assign pol_ok  = (POL_GATE == 0) || (inj_head[VC_BIT] == net_polarity);
  assign net_so  = !inj_empty && net_ro && pol_ok;
  assign inj_pop = net_so;
  assign net_do  = inj_empty ? '0 : inj_head;
  assign net_ri  = reset && !ej_full;

  assign cpu_wr = nicEn && nicWrEn;
  assign cpu_rd = nicEn && !nicWrEn;

  // A write to a full FIFO is still accepted when the router drains the head on the same edge.
  assign inj_push_req = cpu_wr && (addr == 2'b10);
  assign inj_push     = inj_push_req && (!inj_full || inj_pop);
  assign ovf_set      = inj_push_req && inj_full && !inj_pop;
  assign ovf_clr      = cpu_rd && (addr == 2'b11);

  assign ej_push = net_si && net_ri;
  assign ej_pop  = cpu_rd && (addr == 2'b00) && !ej_empty;

  always_comb begin
    d_out = '0;
    if (cpu_rd) begin
      case (addr)
        2'b00: if (!ej_empty) d_out = ej_head;
        2'b01: begin
          d_out[0]    = !ej_empty;
          d_out[CW:1] = ej_count;
        end
        2'b11: begin
          d_out[0]       = inj_full;
          d_out[CW:1]    = inj_count;
          d_out[WIDTH-1] = ovf;
        end
        default: d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wr] <= d_in;
    if (ej_push)  ej_mem[ej_wr]   <= net_di;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_wr    <= '0;
      inj_rd    <= '0;
      inj_count <= '0;
      ej_wr     <= '0;
      ej_rd     <= '0;
      ej_count  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (inj_push) inj_wr <= inj_wr + AW'(1);
      if (inj_pop)  inj_rd <= inj_rd + AW'(1);
      case ({inj_push, inj_pop})
        2'b10:   inj_count <= inj_count + CW'(1);
        2'b01:   inj_count <= inj_count - CW'(1);
        default: inj_count <= inj_count;
      endcase

      if (ej_push) ej_wr <= ej_wr + AW'(1);
      if (ej_pop)  ej_rd <= ej_rd + AW'(1);
      case ({ej_push, ej_pop})
        2'b10:   ej_count <= ej_count + CW'(1);
        2'b01:   ej_count <= ej_count - CW'(1);
        default: ej_count <= ej_count;
      endcase

      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gold_nic_buffered.sv
// Scoreboard bench for gold_nic_buffered: queue-based reference model of both FIFOs,
// directed scenarios followed by randomized CPU/router traffic.
module tb_gold_nic_buffered;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  addr = '0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0, nicWrEn = 1'b0;
  logic        net_polarity = 1'b0;
  logic        net_so, net_ri;
  logic        net_ro = 1'b0, net_si = 1'b0;
  logic [63:0] net_do;
  logic [63:0] net_di = '0;

  gold_nic_buffered #(.WIDTH(64), .DEPTH(DEPTH), .VC_BIT(63), .POL_GATE(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_polarity(net_polarity),
    .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  logic [63:0] inj_q[$];
  logic [63:0] ej_q[$];
  logic [63:0] rd_exp[$];
  bit          ovf_m = 1'b0;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] exp_read(input logic [1:0] a);
    logic [63:0] v;
    v = '0;
    case (a)
      2'b00: if (ej_q.size() > 0) v = ej_q[0];
      2'b01: begin
        v[0]    = (ej_q.size() > 0);
        v[CW:1] = CW'(ej_q.size());
      end
      2'b11: begin
        v[0]    = (inj_q.size() == DEPTH);
        v[CW:1] = CW'(inj_q.size());
        v[63]   = ovf_m;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Reference model: queue contents change at the clock edge using the inputs held across it.
  always @(posedge clk or negedge reset) begin
    bit ri;
    if (!reset) begin
      inj_q.delete();
      ej_q.delete();
      ovf_m = 1'b0;
    end else begin
      ri = (ej_q.size() < DEPTH);
      if (nicEn && nicWrEn && addr == 2'b10) begin
        if (inj_q.size() < DEPTH) inj_q.push_back(d_in);
        else ovf_m = 1'b1;
      end
      if (nicEn && !nicWrEn && addr == 2'b11) ovf_m = 1'b0;
      if (nicEn && !nicWrEn && addr == 2'b00 && ej_q.size() > 0) void'(ej_q.pop_front());
      if (net_si && ri) ej_q.push_back(net_di);
    end
  end

  // Monitor: the router takes the head during the cycle net_so is high, so it is popped here.
  always @(negedge clk) begin
    bit so_e;
    so_e = reset && (inj_q.size() > 0) && net_ro && (inj_q[0][63] == net_polarity);
    chk("net_so", {63'b0, net_so}, {63'b0, so_e});
    chk("net_do", net_do, (inj_q.size() > 0) ? inj_q[0] : 64'b0);
    if (so_e) void'(inj_q.pop_front());
    chk("net_ri", {63'b0, net_ri}, {63'b0, reset && (ej_q.size() < DEPTH)});
    if (nicEn && !nicWrEn) begin
      if (rd_exp.size() == 0) begin
        checks++;
        $display("FAIL rd_scoreboard: got read with no expected entry, required one queued");
      end else begin
        chk("d_out_read", d_out, rd_exp.pop_front());
      end
    end else begin
      chk("d_out_idle", d_out, 64'b0);
    end
  end

  task automatic step(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] d,
                      input logic ro, input logic pol, input logic si, input logic [63:0] di);
    nicEn = en; nicWrEn = wr; addr = a; d_in = d;
    net_ro = ro; net_polarity = pol; net_si = si; net_di = di;
    if (en && !wr) rd_exp.push_back(exp_read(a));
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ro, input logic pol);
    step(1'b0, 1'b0, 2'b00, '0, ro, pol, 1'b0, '0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1: idle after reset, status registers read zero
    idle(1'b1, 1'b0);
    step(1'b1, 1'b0, 2'b01, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 2'b11, '0, 1'b0, 1'b0, 1'b0, '0);

    // 2: fill inject FIFO with router stalled, fifth write dropped, ovf sticky then cleared
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 2'b10, {1'b1, 59'h0, 4'(i + 10)}, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 2'b11, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 2'b11, '0, 1'b0, 1'b0, 1'b0, '0);

    // 3: polarity gating, then drain in order
    repeat (2) idle(1'b1, 1'b0);
    repeat (5) idle(1'b1, 1'b1);

    // 4: eject FIFO fills from the router, CPU drains it
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b1, {32'hE0E0_0000, 32'(i)});
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 2'b01, '0, 1'b0, 1'b0, 1'b0, '0);

    // 5: write lands on a full inject FIFO in the same cycle as a router pop
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 2'b10, {1'b1, 59'h0, 4'(i)}, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 2'b10, {1'b1, 63'h5A5A}, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 2'b11, '0, 1'b0, 1'b0, 1'b0, '0);
    repeat (5) idle(1'b1, 1'b1);

    // 6: reset with two packets in each FIFO
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 2'b10, {1'b0, 63'(i + 100)}, 1'b0, 1'b1, 1'b1, {1'b0, 63'(i + 200)});
    nicEn = 1'b0; nicWrEn = 1'b0; net_si = 1'b0; net_ro = 1'b1; net_polarity = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_net_so", {63'b0, net_so}, 64'b0);
    chk("rst_net_ri", {63'b0, net_ri}, 64'b0);
    chk("rst_net_do", net_do, 64'b0);
    chk("rst_d_out", d_out, 64'b0);
    @(posedge clk); #1 reset = 1'b1;
    step(1'b1, 1'b0, 2'b01, '0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 2'b11, '0, 1'b0, 1'b0, 1'b0, '0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic ro, pol, si;
      ro  = 1'($urandom_range(0, 1));
      pol = 1'($urandom_range(0, 1));
      si  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) begin
        idle(1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
      end else begin
        case ($urandom_range(0, 6))
          0:       step(1'b0, 1'b0, 2'b00, '0, ro, pol, si, rnd64());
          1, 2:    step(1'b1, 1'b1, 2'b10, rnd64(), ro, pol, si, rnd64());
          3:       step(1'b1, 1'b0, 2'b00, '0, ro, pol, si, rnd64());
          4:       step(1'b1, 1'b0, 2'b01, '0, ro, pol, si, rnd64());
          5:       step(1'b1, 1'b0, 2'b11, '0, ro, pol, si, rnd64());
          default: step(1'b1, 1'b1, 2'($urandom_range(0, 1)) | {2{1'($urandom_range(0, 1))}},
                        rnd64(), ro, pol, si, rnd64());
        endcase
      end
    end
    repeat (3) idle(1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
